// File: rtl/router_pkt_tx_if.sv
// Host-side request/payload and router-side packet signals of router_pkt_tx, grouped as one bundle.
// slave is the packet-source view; master is the host and router view that drives the stimulus and busy.
interface router_pkt_tx_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_addr;
  logic [5:0]  req_len;
  logic        pl_valid;
  logic        pl_ready;
  logic [7:0]  pl_data;
  logic        busy;
  logic        inj_parity;
  logic        pkt_valid;
  logic [7:0]  pkt_data;
  logic        pkt_done;
  logic        req_err;
  logic [15:0] pkt_count;

  modport master (
    output req_valid, req_addr, req_len, pl_valid, pl_data, busy, inj_parity,
    input  req_ready, pl_ready, pkt_valid, pkt_data, pkt_done, req_err, pkt_count
  );

  modport slave (
    input  req_valid, req_addr, req_len, pl_valid, pl_data, busy, inj_parity,
    output req_ready, pl_ready, pkt_valid, pkt_data, pkt_done, req_err, pkt_count
  );
endinterface

// File: rtl/router_pkt_tx.sv
// Buffers one host packet, then sends header/payload/parity to the router; header 1 cycle after last load beat,
// busy freezes pkt_valid/pkt_data in place. ROUTER_TX_PARITY_INJ_EN enables inj_parity (flips parity bit 0).
module router_pkt_tx #(
  parameter int GAP_CYCLES = 2,
  parameter int MAX_LEN    = 63
) (
  input logic            clock,
  input logic            reset,
  router_pkt_tx_if.slave bus
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_HDR  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_PAR  = 3'd4;
  localparam logic [2:0] S_GAP  = 3'd5;
  localparam logic [6:0] LEN_MAX  = 7'(MAX_LEN);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  logic [2:0] state, nxt_state;
  logic [5:0] wr_ptr, nxt_wr, rd_ptr, nxt_rd, len_q, nxt_len;
  logic [1:0] addr_q, nxt_addr;
  logic [7:0] parity, nxt_par, gap_cnt, nxt_gap, nxt_dat;
  logic       inj_q, nxt_inj, done_set, err_set, beat;
  logic [7:0] buffer [MAX_LEN];

`ifndef ROUTER_TX_PARITY_INJ_EN
  logic unused_inj;
  assign unused_inj = bus.inj_parity;
`endif

  always_comb begin
    nxt_state = state;
    nxt_wr    = wr_ptr;
    nxt_rd    = rd_ptr;
    nxt_len   = len_q;
    nxt_addr  = addr_q;
    nxt_par   = parity;
    nxt_gap   = gap_cnt;
    nxt_inj   = inj_q;
    done_set  = 1'b0;
    err_set   = 1'b0;
    beat      = 1'b0;
    nxt_dat   = 8'd0;
    case (state)
      S_IDLE: begin
        nxt_wr = '0;
        nxt_rd = '0;
        if (bus.req_valid && bus.req_ready) begin
          if (bus.req_len == 6'd0 || {1'b0, bus.req_len} > LEN_MAX || bus.req_addr == 2'd3) begin
            err_set = 1'b1;
          end else begin
            nxt_state = S_LOAD;
            nxt_len   = bus.req_len;
            nxt_addr  = bus.req_addr;
            nxt_par   = {bus.req_len, bus.req_addr};
`ifdef ROUTER_TX_PARITY_INJ_EN
            nxt_inj   = bus.inj_parity;
`else
            nxt_inj   = 1'b0;
`endif
          end
        end
      end
      S_LOAD: begin
        if (bus.pl_valid && bus.pl_ready) begin
          beat    = 1'b1;
          nxt_wr  = wr_ptr + 6'd1;
          nxt_par = parity ^ bus.pl_data;
          if (nxt_wr == len_q) nxt_state = S_HDR;
        end
      end
      S_HDR: begin
        if (!bus.busy) begin
          nxt_state = S_DATA;
          nxt_rd    = '0;
        end
      end
      S_DATA: begin
        if (!bus.busy) begin
          nxt_rd = rd_ptr + 6'd1;
          if (nxt_rd == len_q) nxt_state = S_PAR;
        end
      end
      S_PAR: begin
        if (!bus.busy) begin
          nxt_state = S_GAP;
          nxt_gap   = 8'd0;
          done_set  = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) nxt_state = S_IDLE;
        else nxt_gap = gap_cnt + 8'd1;
      end
      default: nxt_state = S_IDLE;
    endcase

    // Outputs are registered from the next state, so a stalled byte simply re-registers itself.
    case (nxt_state)
      S_HDR:   nxt_dat = {nxt_len, nxt_addr};
      S_DATA:  nxt_dat = buffer[nxt_rd];
      S_PAR:   nxt_dat = nxt_par ^ {7'd0, nxt_inj};
      default: nxt_dat = 8'd0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      len_q         <= '0;
      addr_q        <= '0;
      parity        <= '0;
      gap_cnt       <= '0;
      inj_q         <= 1'b0;
      bus.req_ready <= 1'b1;
      bus.pl_ready  <= 1'b0;
      bus.pkt_valid <= 1'b0;
      bus.pkt_data  <= 8'd0;
      bus.pkt_done  <= 1'b0;
      bus.req_err   <= 1'b0;
      bus.pkt_count <= 16'd0;
    end else begin
      state         <= nxt_state;
      wr_ptr        <= nxt_wr;
      rd_ptr        <= nxt_rd;
      len_q         <= nxt_len;
      addr_q        <= nxt_addr;
      parity        <= nxt_par;
      gap_cnt       <= nxt_gap;
      inj_q         <= nxt_inj;
      bus.req_ready <= (nxt_state == S_IDLE);
      bus.pl_ready  <= (nxt_state == S_LOAD);
      bus.pkt_valid <= (nxt_state == S_HDR) || (nxt_state == S_DATA);
      bus.pkt_data  <= nxt_dat;
      bus.pkt_done  <= done_set;
      bus.req_err   <= err_set;
      if (done_set) bus.pkt_count <= bus.pkt_count + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (beat) buffer[wr_ptr] <= bus.pl_data;
  end
endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: a driver pushes each packet's expected bytes and parity into queues,
// and an independent negedge monitor pops and compares whatever the router side transfers.
module tb_router_pkt_tx;
  logic clock = 1'b0;
  logic reset = 1'b0;
  router_pkt_tx_if bus();
  router_pkt_tx dut (.clock(clock), .reset(reset), .bus(bus));

  initial forever #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] par_q[$];
  logic [7:0] pay [64];
  bit busy_rand = 1'b0;
  bit busy_force = 1'b0;
  int main_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // busy is updated 2 time units after each posedge so main can request it at +1
  initial begin
    bus.busy = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      bus.busy = busy_force || (busy_rand && $urandom_range(0, 2) == 0);
    end
  end

  // Monitor: router side transfers are popped and compared against the queued expectations.
  initial begin
    int remaining;
    int mon_cnt;
    logic [7:0] last_par, e, p;
    remaining = 0;
    mon_cnt = 0;
    last_par = 8'd0;
    forever begin
      @(negedge clock);
      if (reset) begin
        exp_q.delete();
        par_q.delete();
        remaining = 0;
        mon_cnt = 0;
        continue;
      end
      if (bus.pkt_done) begin
        if (par_q.size() == 0) fail("unexpected_pkt_done");
        else begin
          p = par_q.pop_front();
          chk("parity_byte", last_par, p);
          mon_cnt++;
          chk("pkt_count_mon", bus.pkt_count, mon_cnt);
          chk("gap_data_zero", bus.pkt_data, 8'd0);
        end
      end
      if (bus.pkt_valid) begin
        if (!bus.busy) begin
          if (exp_q.size() == 0) fail("unexpected_pkt_byte");
          else begin
            e = exp_q.pop_front();
            chk("pkt_byte", bus.pkt_data, e);
            if (remaining == 0) remaining = int'(e[7:2]);
            else remaining--;
          end
        end
      end else if (remaining != 0) begin
        fail("pkt_valid_gap");
        remaining = 0;
      end
      if (!bus.pkt_valid && !bus.busy) last_par = bus.pkt_data;
    end
  end

  task automatic send_pkt(input logic [1:0] a, input logic [5:0] l, input bit inj,
                          input bit slow, input bit hold);
    logic [7:0] hdr, par;
    bit rdy, v, tog;
    int i, guard;
    hdr = {l, a};
    if (l != 6'd0 && a != 2'd3) begin
      par = hdr;
      exp_q.push_back(hdr);
      for (int k = 0; k < int'(l); k++) begin
        exp_q.push_back(pay[k]);
        par = par ^ pay[k];
      end
`ifdef ROUTER_TX_PARITY_INJ_EN
      if (inj) par[0] = ~par[0];
`endif
      par_q.push_back(par);
    end
    bus.req_valid = 1'b1;
    bus.req_addr = a;
    bus.req_len = l;
    bus.inj_parity = inj;
    guard = 0;
    do begin
      @(negedge clock);
      rdy = bus.req_ready;
      @(posedge clock);
      #1;
      guard++;
    end while (!rdy && guard < 500);
    bus.req_valid = 1'b0;
    bus.inj_parity = 1'b0;
    if (!rdy) begin
      fail("req_timeout");
      return;
    end
    if (l == 6'd0 || a == 2'd3) begin
      @(negedge clock);
      chk("req_err_pulse", bus.req_err, 1);
      chk("req_ready_after_err", bus.req_ready, 1);
      chk("no_pkt_valid_on_err", bus.pkt_valid, 0);
      @(posedge clock);
      #1;
      @(negedge clock);
      chk("req_err_single", bus.req_err, 0);
      @(posedge clock);
      #1;
      return;
    end
    i = 0;
    guard = 0;
    tog = 1'b0;
    while (i < int'(l) && guard < 2000) begin
      tog = !tog;
      v = slow ? tog : 1'b1;
      bus.pl_valid = v;
      bus.pl_data = pay[i];
      @(negedge clock);
      rdy = bus.pl_ready;
      @(posedge clock);
      #1;
      guard++;
      if (v && rdy) i++;
    end
    bus.pl_valid = 1'b0;
    if (i < int'(l)) begin
      fail("load_timeout");
      return;
    end
    main_cnt++;
    if (hold) busy_force = 1'b1;
    @(negedge clock);
    chk("hdr_latency_valid", bus.pkt_valid, 1);
    chk("hdr_latency_data", bus.pkt_data, hdr);
    chk("pl_ready_drop", bus.pl_ready, 0);
    if (hold) begin
      for (int c = 0; c < 2; c++) begin
        @(posedge clock);
        #1;
        if (c == 1) busy_force = 1'b0;
        @(negedge clock);
        chk("hdr_held_valid", bus.pkt_valid, 1);
        chk("hdr_held_data", bus.pkt_data, hdr);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || par_q.size() != 0) && g < 3000) begin
      @(posedge clock);
      #1;
      g++;
    end
    if (g >= 3000) fail("drain_timeout");
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic fill_random(input int n);
    for (int k = 0; k < n; k++) pay[k] = 8'($urandom);
  endtask

  task automatic fill_basic();
    pay[0] = 8'h11;
    pay[1] = 8'h22;
    pay[2] = 8'h33;
  endtask

  initial begin
    logic [1:0] ra;
    logic [5:0] rl;
    bus.req_valid = 1'b0;
    bus.req_addr = 2'd0;
    bus.req_len = 6'd0;
    bus.pl_valid = 1'b0;
    bus.pl_data = 8'd0;
    bus.inj_parity = 1'b0;
    #2 reset = 1'b1;
    #2;
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_pl_ready", bus.pl_ready, 0);
    chk("rst_pkt_valid", bus.pkt_valid, 0);
    chk("rst_pkt_data", bus.pkt_data, 0);
    chk("rst_pkt_done", bus.pkt_done, 0);
    chk("rst_req_err", bus.req_err, 0);
    chk("rst_pkt_count", bus.pkt_count, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    fill_basic();
    send_pkt(2'd1, 6'd3, 1'b0, 1'b0, 1'b0);
    drain();
    chk("count_basic", bus.pkt_count, main_cnt);

    send_pkt(2'd1, 6'd3, 1'b0, 1'b0, 1'b1);
    drain();

    send_pkt(2'd1, 6'd0, 1'b0, 1'b0, 1'b0);
    send_pkt(2'd3, 6'd5, 1'b0, 1'b0, 1'b0);
    drain();
    chk("count_after_rejects", bus.pkt_count, main_cnt);

    fill_random(63);
    send_pkt(2'd2, 6'd63, 1'b0, 1'b1, 1'b0);
    drain();

    fill_basic();
    send_pkt(2'd1, 6'd3, 1'b1, 1'b0, 1'b0);
    drain();

    busy_rand = 1'b1;
    for (int n = 0; n < 25; n++) begin
      ra = 2'($urandom_range(0, 3));
      rl = ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      fill_random(64);
      send_pkt(ra, rl, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end
    busy_rand = 1'b0;
    drain();
    chk("count_random", bus.pkt_count, main_cnt);

    fill_random(12);
    send_pkt(2'd0, 6'd12, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("midrst_pkt_valid", bus.pkt_valid, 0);
    chk("midrst_pkt_data", bus.pkt_data, 0);
    chk("midrst_req_ready", bus.req_ready, 1);
    chk("midrst_pkt_count", bus.pkt_count, 0);
    @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    main_cnt = 0;

    fill_basic();
    send_pkt(2'd1, 6'd3, 1'b0, 1'b0, 1'b0);
    drain();
    chk("count_after_reset", bus.pkt_count, main_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
